// File: rtl/iic_pkg.sv
// Shared definitions for the I2C EEPROM arbiter: FSM encoding, engine call codes,
// timing defaults and the latched transfer record.
package iic_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CALL  = 2'd1;
    localparam logic [1:0] ST_ABORT = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    localparam logic [1:0] CALL_WR = 2'b10;
    localparam logic [1:0] CALL_RD = 2'b01;

    localparam logic [19:0] TIMEOUT_DEF  = 20'd100000;
    localparam logic [3:0]  GAP_DEF      = 4'd4;
    localparam logic [3:0]  ERST_LEN_DEF = 4'd3;

    typedef struct packed {
        logic       port;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } xfer_t;

    function automatic logic [1:0] call_code(input logic we);
        return we ? CALL_WR : CALL_RD;
    endfunction

endpackage

// File: rtl/iic_arbiter_if.sv
// Requester and EEPROM-engine signals of the arbiter; slave = arbiter side,
// master = requesters plus engine.
interface iic_arbiter_if;

    logic       p0_req;
    logic       p1_req;
    logic       p0_we;
    logic       p1_we;
    logic [7:0] p0_addr;
    logic [7:0] p1_addr;
    logic [7:0] p0_wdata;
    logic [7:0] p1_wdata;
    logic       p0_ack;
    logic       p1_ack;
    logic       p0_err;
    logic       p1_err;
    logic [7:0] rdata;
    logic [1:0] iic_call;
    logic [7:0] iic_addr;
    logic [7:0] iic_data;
    logic       iic_rst_n;
    logic [7:0] iic_odata;
    logic [1:0] iic_done;
    logic       busy;

    modport slave (
        input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
        input  iic_odata, iic_done,
        output p0_ack, p1_ack, p0_err, p1_err, rdata,
        output iic_call, iic_addr, iic_data, iic_rst_n, busy
    );

    modport master (
        output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
        output iic_odata, iic_done,
        input  p0_ack, p1_ack, p0_err, p1_err, rdata,
        input  iic_call, iic_addr, iic_data, iic_rst_n, busy
    );

endinterface

// File: rtl/iic_arbiter.sv
// Round-robin two-port arbiter and call sequencer for the I2C EEPROM engine,
// with a watchdog that pulses the engine reset when a call never completes.
module iic_arbiter
    import iic_pkg::*;
#(
    parameter logic [19:0] TIMEOUT  = TIMEOUT_DEF,
    parameter logic [3:0]  GAP      = GAP_DEF,
    parameter logic [3:0]  ERST_LEN = ERST_LEN_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    iic_arbiter_if.slave  bus
);

    localparam logic [19:0] TO_LAST  = TIMEOUT - 20'd1;
    localparam logic [3:0]  GAP_LAST = GAP - 4'd1;

    logic [1:0]  state;
    xfer_t       xfer;
    logic        rr;
    logic [19:0] cnt;
    logic [3:0]  sub_cnt;
    logic        erst;
    logic        gnt;
    logic        sel_we;
    logic [7:0]  sel_addr;
    logic [7:0]  sel_wdata;
    logic        done_hit;

    // Both requesting: the port that did not win last time goes next.
    always_comb begin
        gnt = 1'b0;
        if (bus.p0_req && bus.p1_req) begin
            gnt = ~rr;
        end else begin
            gnt = bus.p1_req;
        end
        sel_we    = gnt ? bus.p1_we    : bus.p0_we;
        sel_addr  = gnt ? bus.p1_addr  : bus.p0_addr;
        sel_wdata = gnt ? bus.p1_wdata : bus.p0_wdata;
    end

    // Only the done bit matching the call direction completes the transfer.
    assign done_hit      = xfer.we ? bus.iic_done[1] : bus.iic_done[0];
    assign bus.iic_addr  = xfer.addr;
    assign bus.iic_data  = xfer.wdata;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.iic_rst_n = erst & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            xfer         <= '0;
            rr           <= 1'b0;
            cnt          <= '0;
            sub_cnt      <= '0;
            erst         <= 1'b1;
            bus.iic_call <= 2'b00;
            bus.p0_ack   <= 1'b0;
            bus.p1_ack   <= 1'b0;
            bus.p0_err   <= 1'b0;
            bus.p1_err   <= 1'b0;
            bus.rdata    <= '0;
        end else begin
            bus.p0_ack <= 1'b0;
            bus.p1_ack <= 1'b0;
            bus.p0_err <= 1'b0;
            bus.p1_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.p0_req || bus.p1_req) begin
                        xfer         <= '{port: gnt, we: sel_we, addr: sel_addr, wdata: sel_wdata};
                        rr           <= gnt;
                        cnt          <= '0;
                        bus.iic_call <= call_code(sel_we);
                        state        <= ST_CALL;
                    end
                end
                ST_CALL: begin
                    if (done_hit) begin
                        bus.iic_call <= 2'b00;
                        if (!xfer.we) begin
                            bus.rdata <= bus.iic_odata;
                        end
                        if (xfer.port) begin
                            bus.p1_ack <= 1'b1;
                        end else begin
                            bus.p0_ack <= 1'b1;
                        end
                        sub_cnt <= '0;
                        state   <= ST_GAP;
                    end else if (cnt == TO_LAST) begin
                        bus.iic_call <= 2'b00;
                        sub_cnt      <= '0;
                        state        <= ST_ABORT;
                    end else if (cnt != 20'hFFFFF) begin
                        cnt <= cnt + 20'd1;
                    end
                end
                // Engine reset is held low for ERST_LEN cycles, then the abort is reported.
                ST_ABORT: begin
                    if (sub_cnt == ERST_LEN) begin
                        erst <= 1'b1;
                        if (xfer.port) begin
                            bus.p1_ack <= 1'b1;
                            bus.p1_err <= 1'b1;
                        end else begin
                            bus.p0_ack <= 1'b1;
                            bus.p0_err <= 1'b1;
                        end
                        sub_cnt <= '0;
                        state   <= ST_GAP;
                    end else begin
                        erst    <= 1'b0;
                        sub_cnt <= sub_cnt + 4'd1;
                    end
                end
                default: begin
                    if (sub_cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        sub_cnt <= sub_cnt + 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iic_arbiter.sv
// Directed bench for iic_arbiter: write, read, round-robin, mid-transfer reset and
// watchdog abort (second instance with a short timeout).
module tb_iic_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    int   bad;
    int   gapbad;
    int   k;
    logic exp_port [3] = '{1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    iic_arbiter_if bus ();
    iic_arbiter_if tbus ();

    iic_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    iic_arbiter #(.TIMEOUT(20'd200)) tdut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tbus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1'b0;
        bus.p0_req = 0; bus.p1_req = 0; bus.p0_we = 0; bus.p1_we = 0;
        bus.p0_addr = 0; bus.p1_addr = 0; bus.p0_wdata = 0; bus.p1_wdata = 0;
        bus.iic_odata = 0; bus.iic_done = 0;
        tbus.p0_req = 0; tbus.p1_req = 0; tbus.p0_we = 0; tbus.p1_we = 0;
        tbus.p0_addr = 0; tbus.p1_addr = 0; tbus.p0_wdata = 0; tbus.p1_wdata = 0;
        tbus.iic_odata = 0; tbus.iic_done = 0;
        tick(); tick();

        chk("rst_call",  32'(bus.iic_call), 32'h0);
        chk("rst_busy",  32'(bus.busy), 32'h0);
        chk("rst_ack0",  32'(bus.p0_ack), 32'h0);
        chk("rst_ack1",  32'(bus.p1_ack), 32'h0);
        chk("rst_err0",  32'(bus.p0_err), 32'h0);
        chk("rst_rdata", 32'(bus.rdata), 32'h0);
        chk("rst_addr",  32'(bus.iic_addr), 32'h0);
        chk("rst_tcall", 32'(tbus.iic_call), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("rst_iic_rst_n", 32'(bus.iic_rst_n), 32'h1);
        chk("rst_idle_busy", 32'(bus.busy), 32'h0);

        // p0 write 0x10 <= 0xA5, engine done after 4000 call cycles
        bus.p0_req = 1; bus.p0_we = 1; bus.p0_addr = 8'h10; bus.p0_wdata = 8'hA5;
        tick();
        chk("wr_call", 32'(bus.iic_call), 32'h2);
        chk("wr_addr", 32'(bus.iic_addr), 32'h10);
        chk("wr_data", 32'(bus.iic_data), 32'hA5);
        chk("wr_busy", 32'(bus.busy), 32'h1);
        bad = 0;
        for (int i = 2; i <= 4000; i++) begin
            tick();
            if (bus.iic_call !== 2'b10 || bus.p0_ack !== 1'b0) bad++;
        end
        chk("wr_call_span", 32'(bad), 32'h0);
        bus.iic_done = 2'b10;
        tick();
        bus.iic_done = 2'b00; bus.p0_req = 0;
        chk("wr_ack",      32'(bus.p0_ack), 32'h1);
        chk("wr_err",      32'(bus.p0_err), 32'h0);
        chk("wr_call_off", 32'(bus.iic_call), 32'h0);
        chk("wr_p1_ack",   32'(bus.p1_ack), 32'h0);
        tick();
        chk("wr_ack_pulse", 32'(bus.p0_ack), 32'h0);
        tick(); tick();
        chk("wr_gap_busy", 32'(bus.busy), 32'h1);
        tick();
        chk("wr_busy_low", 32'(bus.busy), 32'h0);

        // p1 read 0x20 with a spurious write-done in the middle
        bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 8'h20;
        tick();
        chk("rd_call", 32'(bus.iic_call), 32'h1);
        chk("rd_addr", 32'(bus.iic_addr), 32'h20);
        tick(); tick();
        bus.iic_done = 2'b10; bus.iic_odata = 8'h77;
        tick();
        bus.iic_done = 2'b00;
        chk("rd_spur_call",  32'(bus.iic_call), 32'h1);
        chk("rd_spur_ack",   32'(bus.p1_ack), 32'h0);
        chk("rd_spur_rdata", 32'(bus.rdata), 32'h0);
        tick();
        bus.iic_done = 2'b01; bus.iic_odata = 8'h3C;
        tick();
        bus.iic_done = 2'b00; bus.p1_req = 0; bus.iic_odata = 8'h00;
        chk("rd_ack",   32'(bus.p1_ack), 32'h1);
        chk("rd_err",   32'(bus.p1_err), 32'h0);
        chk("rd_rdata", 32'(bus.rdata), 32'h3C);
        chk("rd_call_off", 32'(bus.iic_call), 32'h0);
        repeat (4) tick();
        chk("rd_rdata_hold", 32'(bus.rdata), 32'h3C);

        // Reset so rr starts at 0, then three contested rounds
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        bus.p0_we = 1; bus.p0_addr = 8'h01; bus.p0_wdata = 8'h11;
        bus.p1_we = 0; bus.p1_addr = 8'h02;
        bus.p0_req = 1; bus.p1_req = 1;
        gapbad = 0;
        for (int r = 0; r < 3; r++) begin
            k = 0;
            while (bus.iic_call === 2'b00 && k < 20) begin
                tick();
                k++;
            end
            chk($sformatf("rr%0d_granted", r), 32'(k < 20), 32'h1);
            chk($sformatf("rr%0d_addr", r), 32'(bus.iic_addr), exp_port[r] ? 32'h02 : 32'h01);
            chk($sformatf("rr%0d_call", r), 32'(bus.iic_call), exp_port[r] ? 32'h1 : 32'h2);
            tick();
            if (bus.iic_call === 2'b11) gapbad++;
            bus.iic_done = exp_port[r] ? 2'b01 : 2'b10;
            bus.iic_odata = 8'hC0 + 8'(r);
            tick();
            bus.iic_done = 2'b00;
            chk($sformatf("rr%0d_ack0", r), 32'(bus.p0_ack), exp_port[r] ? 32'h0 : 32'h1);
            chk($sformatf("rr%0d_ack1", r), 32'(bus.p1_ack), exp_port[r] ? 32'h1 : 32'h0);
            if (bus.iic_call !== 2'b00) gapbad++;
            for (int g = 0; g < 3; g++) begin
                tick();
                if (bus.iic_call !== 2'b00) gapbad++;
            end
        end
        bus.p0_req = 0; bus.p1_req = 0;
        chk("rr_gap_call", 32'(gapbad), 32'h0);
        chk("rr_rdata", 32'(bus.rdata), 32'hC2);
        tick(); tick();

        // Asynchronous reset 50 cycles into a write
        bus.p0_req = 1; bus.p0_we = 1; bus.p0_addr = 8'h40; bus.p0_wdata = 8'h5E;
        tick();
        chk("rm_call", 32'(bus.iic_call), 32'h2);
        repeat (50) tick();
        rst_n = 1'b0;
        #1;
        chk("rm_call_drop", 32'(bus.iic_call), 32'h0);
        chk("rm_busy",      32'(bus.busy), 32'h0);
        chk("rm_ack",       32'(bus.p0_ack), 32'h0);
        chk("rm_addr",      32'(bus.iic_addr), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rm_regrant",  32'(bus.iic_call), 32'h2);
        chk("rm_no_ack",   32'(bus.p0_ack), 32'h0);
        chk("rm_iic_rstn", 32'(bus.iic_rst_n), 32'h1);
        tick();
        bus.iic_done = 2'b10;
        tick();
        bus.iic_done = 2'b00; bus.p0_req = 0;
        chk("rm_ack2", 32'(bus.p0_ack), 32'h1);
        repeat (4) tick();

        // Watchdog on the TIMEOUT=200 instance; a good read first sets rdata
        tbus.p1_req = 1; tbus.p1_we = 0; tbus.p1_addr = 8'h30;
        tick();
        tbus.iic_done = 2'b01; tbus.iic_odata = 8'h5A;
        tick();
        tbus.iic_done = 2'b00; tbus.p1_req = 0; tbus.iic_odata = 8'h00;
        chk("to_pre_ack",   32'(tbus.p1_ack), 32'h1);
        chk("to_pre_rdata", 32'(tbus.rdata), 32'h5A);
        repeat (4) tick();
        tbus.p1_req = 1; tbus.p1_addr = 8'h31;
        tick();
        chk("to_call", 32'(tbus.iic_call), 32'h1);
        bad = 0;
        for (int i = 2; i <= 200; i++) begin
            tick();
            if (tbus.iic_call !== 2'b01 || tbus.iic_rst_n !== 1'b1) bad++;
        end
        chk("to_span", 32'(bad), 32'h0);
        tick();
        chk("to_call_fall", 32'(tbus.iic_call), 32'h0);
        chk("to_rstn_t0",   32'(tbus.iic_rst_n), 32'h1);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (tbus.iic_rst_n !== 1'b0 || tbus.p1_ack !== 1'b0) bad++;
        end
        chk("to_rstn_low", 32'(bad), 32'h0);
        tick();
        tbus.p1_req = 0;
        chk("to_rstn_back", 32'(tbus.iic_rst_n), 32'h1);
        chk("to_ack",       32'(tbus.p1_ack), 32'h1);
        chk("to_err",       32'(tbus.p1_err), 32'h1);
        chk("to_rdata",     32'(tbus.rdata), 32'h5A);
        repeat (5) tick();
        chk("to_idle", 32'(tbus.busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
